// File: rtl/spi_cmd_queue.sv
// ---------------------------------------------------------------------------
// spi_cmd_queue
//
// Command buffer / sequencer sitting directly in front of a 16-bit SPI master.
// Commands arrive on a valid/ready port and are queued in a circular FIFO.
// They are issued to the master one at a time (spi_wrt pulse with spi_cmd).
// The sequencer then waits for the master's done rising edge and returns the
// received word on resp_data/resp_vld. Responses come back in push order.
//
// Optional feature macro: SPI_TIMEOUT_EN
//   When defined, a WAIT that lasts TIMEOUT_CYC cycles without completion
//   returns 16'hFFFF and sets the sticky resp_err flag. The sequencer then
//   parks in HALT until reset. When undefined, WAIT waits forever and
//   resp_err is tied low.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous reset, active high
//   cmd_in       in   16       command word to queue
//   cmd_vld      in   1        cmd_in valid (push on cmd_vld & cmd_rdy)
//   cmd_rdy      out  1        FIFO not full
//   fifo_cnt     out  PTR_W+1  entries currently queued
//   spi_wrt      out  1        one-cycle start pulse to the SPI master
//   spi_cmd      out  16       command to the SPI master
//   spi_done     in   1        master done level (cleared by master on wrt)
//   spi_rd_data  in   16       word received by the master
//   resp_data    out  16       last returned word, held until the next one
//   resp_vld     out  1        one-cycle pulse when resp_data updates
//   resp_err     out  1        sticky timeout flag
//   busy         out  1        sequencer not in IDLE
// ---------------------------------------------------------------------------
module spi_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
`ifdef SPI_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cmd_in,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  output logic [PTR_W:0]   fifo_cnt,
  output logic             spi_wrt,
  output logic [15:0]      spi_cmd,
  input  logic             spi_done,
  input  logic [15:0]      spi_rd_data,
  output logic [15:0]      resp_data,
  output logic             resp_vld,
  output logic             resp_err,
  output logic             busy
);

`ifdef SPI_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   cnt_reg;
  logic             push;
  logic             pop;

  // Sequencer
  state_t           state_reg;
  state_t           state_next;
  logic             load_cmd;
  logic             resp_load;
  logic [15:0]      resp_word;
  logic             done_q_reg;
  logic             completion;

  // Output registers
  logic [15:0]      spi_cmd_reg;
  logic [15:0]      resp_data_reg;
  logic             resp_vld_reg;

`ifdef SPI_TIMEOUT_EN
  logic [9:0]       tmo_cnt_reg;
  logic             tmo_hit;
  logic             err_set;
  logic             resp_err_reg;
`endif

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  assign cmd_rdy  = (cnt_reg != FULL_CNT);
  assign fifo_cnt = cnt_reg;
  assign push     = cmd_vld & cmd_rdy;
  // The head leaves the FIFO in the same cycle it is presented to the master.
  assign pop      = (state_reg == ISSUE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cmd_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain modulo arithmetic.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Completion detect: only a rising edge of done counts, so a level left
  // high from an earlier transfer can never complete a new one.
  // -------------------------------------------------------------------------
  assign completion = spi_done & ~done_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q_reg <= 1'b0;
    end else begin
      done_q_reg <= spi_done;
    end
  end

`ifdef SPI_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // WAIT watchdog: zero during the first WAIT cycle, so the Nth WAIT cycle
  // sees N-1 and expiry lands on the TIMEOUT_CYC-th WAIT cycle.
  // -------------------------------------------------------------------------
  assign tmo_hit = (tmo_cnt_reg == 10'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      tmo_cnt_reg <= tmo_cnt_reg + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_reg <= 1'b0;
    end else if (err_set) begin
      resp_err_reg <= 1'b1;
    end
  end

  assign resp_err = resp_err_reg;
`else
  assign resp_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_cmd   = 1'b0;
    resp_load  = 1'b0;
    resp_word  = spi_rd_data;
`ifdef SPI_TIMEOUT_EN
    err_set    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (cnt_reg != '0) begin
          // Capture the head now so spi_cmd is already stable while wrt is high.
          load_cmd   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        // A completion in the expiry cycle still counts as a normal response.
        if (completion) begin
          resp_load  = 1'b1;
          resp_word  = spi_rd_data;
          state_next = IDLE;
        end
`ifdef SPI_TIMEOUT_EN
        else if (tmo_hit) begin
          resp_load  = 1'b1;
          resp_word  = 16'hFFFF;
          err_set    = 1'b1;
          state_next = HALT;
        end
`endif
      end
`ifdef SPI_TIMEOUT_EN
      HALT: begin
        state_next = HALT;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cmd_reg <= '0;
    end else if (load_cmd) begin
      spi_cmd_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_reg <= '0;
      resp_vld_reg  <= 1'b0;
    end else begin
      resp_vld_reg <= resp_load;
      if (resp_load) begin
        resp_data_reg <= resp_word;
      end
    end
  end

  assign spi_wrt   = (state_reg == ISSUE);
  assign spi_cmd   = spi_cmd_reg;
  assign resp_data = resp_data_reg;
  assign resp_vld  = resp_vld_reg;
  assign busy      = (state_reg != IDLE);

endmodule
